// File: rtl/usb_tx_phy.sv
// USB 1.1 full-speed transmit PHY: UTMI byte handshake in, sync + bit-stuffed
// NRZI serial stream + EOP out on txdp/txdn/txoe, paced by the 12 MHz bit enable.
module usb_tx_phy #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fs_ce,
  input  logic [7:0] DataOut_i,
  input  logic       TxValid_i,
  output logic       TxReady_o,
  output logic       txdp,
  output logic       txdn,
  output logic       txoe
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, EOP3} state_t;

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

  state_t     state, state_nx;
  logic [7:0] shreg, shreg_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [2:0] ones_cnt, ones_cnt_nx;
  logic       txdp_nx, txdn_nx, txoe_nx;
  logic       tx_active, stuff_now, byte_end;
  logic       send_v, send_bit;
  logic [2:0] bit_idx;

  // A 0 toggles the differential line, a 1 holds it.
  function automatic logic [1:0] nrzi(input logic b, input logic [1:0] line);
    return b ? line : ~line;
  endfunction

  function automatic logic [2:0] ones_next(input logic b, input logic [2:0] cnt);
    return b ? cnt + 3'd1 : 3'd0;
  endfunction

  // bit_cnt indexes the bit currently on the line; the boundary edge is the
  // one that ends bit 7 (or the stuff bit that follows it).
  always_comb begin
    tx_active = (state == SYNC) || (state == DATA);
    stuff_now = tx_active && (ones_cnt == STUFF_CNT);
    byte_end  = tx_active && !stuff_now && (bit_cnt == 3'd7);
    TxReady_o = fs_ce && byte_end && TxValid_i;
  end

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_cnt_nx  = bit_cnt;
    ones_cnt_nx = ones_cnt;
    txdp_nx     = txdp;
    txdn_nx     = txdn;
    txoe_nx     = txoe;
    send_v      = 1'b0;
    send_bit    = 1'b0;
    bit_idx     = bit_cnt + 3'd1;

    case (state)
      IDLE: begin
        if (TxValid_i) begin
          state_nx    = SYNC;
          shreg_nx    = SYNC_BYTE;
          bit_cnt_nx  = 3'd0;
          ones_cnt_nx = 3'd0;
          txoe_nx     = 1'b1;
          send_v      = 1'b1;
          send_bit    = SYNC_BYTE[0];
        end
      end
      SYNC, DATA: begin
        if (stuff_now) begin
          send_v   = 1'b1;
          send_bit = 1'b0;
        end else if (bit_cnt == 3'd7) begin
          if (TxValid_i) begin
            state_nx   = DATA;
            shreg_nx   = DataOut_i;
            bit_cnt_nx = 3'd0;
            send_v     = 1'b1;
            send_bit   = DataOut_i[0];
          end else begin
            state_nx    = EOP1;
            txdp_nx     = 1'b0;
            txdn_nx     = 1'b0;
            ones_cnt_nx = 3'd0;
          end
        end else begin
          bit_cnt_nx = bit_idx;
          send_v     = 1'b1;
          send_bit   = shreg[bit_idx];
        end
      end
      EOP1: state_nx = EOP2;
      EOP2: begin
        state_nx = EOP3;
        txdp_nx  = 1'b1;
        txdn_nx  = 1'b0;
      end
      EOP3: begin
        state_nx = IDLE;
        txoe_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase

    if (send_v) begin
      {txdp_nx, txdn_nx} = nrzi(send_bit, {txdp, txdn});
      ones_cnt_nx        = ones_next(send_bit, ones_cnt_nx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      txdp     <= 1'b1;
      txdn     <= 1'b0;
      txoe     <= 1'b0;
    end else if (fs_ce) begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_cnt_nx;
      ones_cnt <= ones_cnt_nx;
      txdp     <= txdp_nx;
      txdn     <= txdn_nx;
      txoe     <= txoe_nx;
    end
  end

endmodule
